uart_frame_assembler: RTL and testbench

//  Sits between the UART byte receiver and the 32-channel I2S transmitter.

---
 rtl/uart_frame_pkg.sv | 19 +
 rtl/frame_gap_timer.sv | 33 +++
 rtl/uart_frame_assembler.sv | 184 ++++++++++++++++++
 tb/tb_uart_frame_assembler.sv | 322 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_frame_pkg.sv
// Shared types and defaults for the UART frame assembler slice.
// State encoding, channel byte type and default sync/gap constants.
package uart_frame_pkg;

    typedef enum logic [2:0] {
        HUNT,
        SYNC,
        PAYLOAD,
        CSUM,
        COMMIT
    } state_t;

    typedef logic [7:0] chan_t;

    localparam chan_t DEF_SYNC0      = 8'hA5;
    localparam chan_t DEF_SYNC1      = 8'h5A;
    localparam int    DEF_GAP_CYCLES = 50000;

endpackage

// File: rtl/frame_gap_timer.sv
// Inter-byte gap watchdog: down-counter reloaded on each byte.
// Fires once GAP_CYCLES idle cycles have elapsed while running.
module frame_gap_timer
    import uart_frame_pkg::*;
#(
    parameter int GAP_CYCLES = DEF_GAP_CYCLES
) (
    input  logic clk,
    input  logic rst_n,
    input  logic run,
    input  logic reload,
    output logic timeout
);

    localparam int W = $clog2(GAP_CYCLES + 1);
    localparam logic [W-1:0] LOAD = W'(GAP_CYCLES);
    localparam logic [W-1:0] ONE  = W'(1);

    logic [W-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= LOAD;
        end else if (reload || !run) begin
            cnt <= LOAD;
        end else if (cnt != '0) begin
            cnt <= cnt - ONE;
        end
    end

    assign timeout = run && !reload && (cnt == '0);

endmodule

// File: rtl/uart_frame_assembler.sv
// UART byte stream -> NUM_CH-channel frame publisher with ready/ack handshake.
// Optional trailing sum byte is enabled by defining CHECKSUM_EN.
module uart_frame_assembler
    import uart_frame_pkg::*;
#(
    parameter int    NUM_CH     = 32,
    parameter chan_t SYNC0      = DEF_SYNC0,
    parameter chan_t SYNC1      = DEF_SYNC1,
    parameter int    GAP_CYCLES = DEF_GAP_CYCLES
) (
    input  logic       clk,
    input  logic       rst_n,
    input  chan_t      rx_byte,
    input  logic       rx_byte_valid,
    output chan_t      out_channel_data [NUM_CH],
    output logic       data_ready,
    input  logic       data_acknowledge,
    output logic [7:0] frame_err_cnt,
    output logic [7:0] overrun_cnt,
    output logic       busy
);

    localparam int IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam logic [IDX_W-1:0] LAST    = IDX_W'(NUM_CH - 1);
    localparam logic [IDX_W-1:0] IDX_ONE = IDX_W'(1);

    state_t state, state_nxt;

    logic [IDX_W-1:0] idx;
    chan_t            shadow [NUM_CH];
`ifdef CHECKSUM_EN
    chan_t            sum;
`endif

    logic gap_to;
    logic start;
    logic store;
    logic commit;
    logic err_evt;
    logic accept;
    logic overrun;

    assign busy = (state != HUNT);

    frame_gap_timer #(
        .GAP_CYCLES (GAP_CYCLES)
    ) u_gap (
        .clk     (clk),
        .rst_n   (rst_n),
        .run     (busy),
        .reload  (rx_byte_valid),
        .timeout (gap_to)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= HUNT;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        start     = 1'b0;
        store     = 1'b0;
        commit    = 1'b0;
        err_evt   = 1'b0;
        if (gap_to) begin
            state_nxt = HUNT;
            err_evt   = 1'b1;
        end else begin
            unique case (state)
                HUNT: begin
                    if (rx_byte_valid && rx_byte == SYNC0) begin
                        state_nxt = SYNC;
                    end
                end
                SYNC: begin
                    if (rx_byte_valid) begin
                        if (rx_byte == SYNC1) begin
                            state_nxt = PAYLOAD;
                            start     = 1'b1;
                        end else if (rx_byte != SYNC0) begin
                            state_nxt = HUNT;
                        end
                    end
                end
                PAYLOAD: begin
                    if (rx_byte_valid) begin
                        store = 1'b1;
                        if (idx == LAST) begin
`ifdef CHECKSUM_EN
                            state_nxt = CSUM;
`else
                            state_nxt = COMMIT;
`endif
                        end
                    end
                end
                CSUM: begin
`ifdef CHECKSUM_EN
                    if (rx_byte_valid) begin
                        if (rx_byte == sum) begin
                            state_nxt = COMMIT;
                        end else begin
                            state_nxt = HUNT;
                            err_evt   = 1'b1;
                        end
                    end
`else
                    state_nxt = HUNT;
`endif
                end
                COMMIT: begin
                    commit    = 1'b1;
                    state_nxt = HUNT;
                end
                default: state_nxt = HUNT;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx <= '0;
        end else if (start) begin
            idx <= '0;
        end else if (store) begin
            idx <= idx + IDX_ONE;
        end
    end

`ifdef CHECKSUM_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum <= '0;
        end else if (start) begin
            sum <= '0;
        end else if (store) begin
            sum <= sum + rx_byte;
        end
    end
`endif

    // Shadow is always fully rewritten before a commit, so it needs no reset.
    always_ff @(posedge clk) begin
        if (store) begin
            shadow[idx] <= rx_byte;
        end
    end

    assign accept  = commit && (!data_ready || data_acknowledge);
    assign overrun = commit && data_ready && !data_acknowledge;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_CH; i++) begin
                out_channel_data[i] <= '0;
            end
            data_ready <= 1'b0;
        end else if (accept) begin
            out_channel_data <= shadow;
            data_ready       <= 1'b1;
        end else if (data_ready && data_acknowledge) begin
            data_ready <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_err_cnt <= '0;
            overrun_cnt   <= '0;
        end else begin
            if (err_evt && frame_err_cnt != 8'hFF) begin
                frame_err_cnt <= frame_err_cnt + 8'd1;
            end
            if (overrun && overrun_cnt != 8'hFF) begin
                overrun_cnt <= overrun_cnt + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_uart_frame_assembler.sv
// Scoreboard bench for uart_frame_assembler: directed scenarios then random frames.
// Honours CHECKSUM_EN the same way as the design.
module tb_uart_frame_assembler;
    import uart_frame_pkg::*;

    localparam int NUM_CH = 32;
    localparam int GAP    = 64;

    typedef logic [8*NUM_CH-1:0] frame_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    chan_t      rx_byte = '0;
    logic       rx_byte_valid = 1'b0;
    chan_t      out_channel_data [NUM_CH];
    logic       data_ready;
    logic       data_acknowledge;
    logic [7:0] frame_err_cnt;
    logic [7:0] overrun_cnt;
    logic       busy;

    logic mon_ack = 1'b0;
    logic dir_ack = 1'b0;
    assign data_acknowledge = mon_ack | dir_ack;

    always #5 clk = ~clk;

    uart_frame_assembler #(
        .NUM_CH     (NUM_CH),
        .SYNC0      (DEF_SYNC0),
        .SYNC1      (DEF_SYNC1),
        .GAP_CYCLES (GAP)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .rx_byte          (rx_byte),
        .rx_byte_valid    (rx_byte_valid),
        .out_channel_data (out_channel_data),
        .data_ready       (data_ready),
        .data_acknowledge (data_acknowledge),
        .frame_err_cnt    (frame_err_cnt),
        .overrun_cnt      (overrun_cnt),
        .busy             (busy)
    );

    int     n_checks = 0;
    int     n_fail   = 0;
    frame_t sb [$];
    bit     auto_ack = 1'b1;
    int     exp_err  = 0;
    int     exp_ovr  = 0;

    function automatic frame_t pack_out();
        frame_t f;
        for (int i = 0; i < NUM_CH; i++) f[8*i +: 8] = out_channel_data[i];
        return f;
    endfunction

    function automatic chan_t sum_of(input frame_t f);
        chan_t s;
        s = '0;
        for (int i = 0; i < NUM_CH; i++) s = s + f[8*i +: 8];
        return s;
    endfunction

    function automatic frame_t rand_frame();
        frame_t f;
        for (int i = 0; i < NUM_CH; i++) f[8*i +: 8] = 8'($urandom);
        return f;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_frame(input string name, input frame_t act, input frame_t exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor/consumer: compare every newly presented frame against the queue.
    initial begin
        bit need_check = 1'b1;
        bit consume    = 1'b0;
        bit ack_pend   = 1'b0;
        int ack_wait   = 0;
        forever begin
            @(negedge clk);
            #1;
            if (consume || !data_ready) need_check = 1'b1;
            if (data_ready && need_check) begin
                need_check = 1'b0;
                if (sb.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_frame: got %h expected none", pack_out());
                end else begin
                    chk_frame("frame", pack_out(), sb.pop_front());
                end
                if (auto_ack) begin
                    ack_pend = 1'b1;
                    ack_wait = $urandom_range(0, 3);
                end
            end
            mon_ack = 1'b0;
            if (ack_pend) begin
                if (ack_wait == 0) begin
                    mon_ack  = 1'b1;
                    ack_pend = 1'b0;
                end else begin
                    ack_wait--;
                end
            end
            consume = (mon_ack | dir_ack) && data_ready;
        end
    end

    task automatic send_byte(input chan_t b, input int gap);
        @(negedge clk);
        rx_byte       = b;
        rx_byte_valid = 1'b1;
        @(negedge clk);
        rx_byte_valid = 1'b0;
        repeat (gap) @(negedge clk);
    endtask

    task automatic send_frame(input frame_t f, input bit publish, input bit corrupt,
                              input bit check_lat, input bit ack_at_commit);
        chan_t bytes [$];
        chan_t last;
        bytes.push_back(DEF_SYNC0);
        bytes.push_back(DEF_SYNC1);
        for (int i = 0; i < NUM_CH; i++) bytes.push_back(f[8*i +: 8]);
`ifdef CHECKSUM_EN
        bytes.push_back(sum_of(f) ^ {7'd0, corrupt});
`else
        if (corrupt) bytes.push_back(sum_of(f));
`endif
        last = bytes.pop_back();
        for (int k = 0; k < bytes.size(); k++) send_byte(bytes[k], $urandom_range(0, 4));
        if (publish) sb.push_back(f);
        @(negedge clk);
        rx_byte       = last;
        rx_byte_valid = 1'b1;
        @(negedge clk);
        rx_byte_valid = 1'b0;
        if (check_lat) chk("latency_lo", data_ready, 0);
        if (ack_at_commit) dir_ack = 1'b1;
        @(negedge clk);
        dir_ack = 1'b0;
        if (check_lat) chk("latency_hi", data_ready, 1);
    endtask

    task automatic wait_idle();
        int n = 0;
        while (!(sb.size() == 0 && !data_ready) && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk("drain", (sb.size() == 0 && !data_ready), 1);
    endtask

    task automatic ack_pulse();
        @(negedge clk);
        dir_ack = 1'b1;
        @(negedge clk);
        dir_ack = 1'b0;
    endtask

    task automatic chk_counters(input string tag);
        chk({tag, "_err"}, frame_err_cnt, exp_err);
        chk({tag, "_ovr"}, overrun_cnt, exp_ovr);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        frame_t f, f2;
        #12;
        chk("rst_ready", data_ready, 0);
        chk("rst_busy", busy, 0);
        chk_counters("rst");
        chk_frame("rst_data", pack_out(), '0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        // Incrementing payload 01..20
        for (int i = 0; i < NUM_CH; i++) f[8*i +: 8] = 8'(i + 1);
        send_frame(f, 1, 0, 1, 0);
        chk("t1_ch0", out_channel_data[0], 8'h01);
        chk("t1_ch31", out_channel_data[NUM_CH-1], 8'h20);
        wait_idle();
        chk_counters("t1");

`ifdef CHECKSUM_EN
        send_frame(f, 0, 1, 0, 0);
        exp_err++;
        repeat (4) @(negedge clk);
        chk("t2_ready", data_ready, 0);
        chk_counters("t2");
        send_frame(rand_frame(), 1, 0, 1, 0);
        wait_idle();
`endif

        // Overrun while the consumer stalls
        auto_ack = 1'b0;
        f  = rand_frame();
        f2 = rand_frame();
        send_frame(f, 1, 0, 1, 0);
        send_frame(f2, 0, 0, 0, 0);
        exp_ovr++;
        repeat (2) @(negedge clk);
        chk_counters("t3");
        chk("t3_ready", data_ready, 1);
        chk_frame("t3_hold", pack_out(), f);
        ack_pulse();
        chk("t3_ack_clr", data_ready, 0);

        // Acknowledge lands in the COMMIT cycle
        f  = rand_frame();
        f2 = rand_frame();
        send_frame(f, 1, 0, 1, 0);
        send_frame(f2, 1, 0, 0, 1);
        chk("t4_ready", data_ready, 1);
        chk_frame("t4_data", pack_out(), f2);
        chk_counters("t4");
        repeat (2) @(negedge clk);
        ack_pulse();
        chk("t4_ack_clr", data_ready, 0);
        auto_ack = 1'b1;

        // Stream stalls mid-payload
        send_byte(DEF_SYNC0, 1);
        send_byte(DEF_SYNC1, 1);
        for (int i = 0; i < 10; i++) send_byte(8'($urandom), 1);
        chk("t5_busy_hi", busy, 1);
        repeat (GAP + 4) @(negedge clk);
        exp_err++;
        chk("t5_busy_lo", busy, 0);
        chk_counters("t5");
        send_frame(rand_frame(), 1, 0, 1, 0);
        wait_idle();

        // Error counter saturates
        repeat (260) begin
            send_byte(DEF_SYNC0, GAP + 4);
            if (exp_err < 255) exp_err++;
        end
        chk_counters("sat");

        // Repeated first sync byte
        send_byte(DEF_SYNC0, 2);
        send_frame(rand_frame(), 1, 0, 1, 0);
        wait_idle();

        // Reset mid-payload with a frame pending
        auto_ack = 1'b0;
        send_frame(rand_frame(), 1, 0, 1, 0);
        send_byte(DEF_SYNC0, 1);
        send_byte(DEF_SYNC1, 1);
        for (int i = 0; i < 5; i++) send_byte(8'($urandom), 1);
        chk("t6_busy_hi", busy, 1);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        exp_err = 0;
        exp_ovr = 0;
        chk("t6_ready", data_ready, 0);
        chk("t6_busy", busy, 0);
        chk_counters("t6");
        chk_frame("t6_data", pack_out(), '0);
        @(negedge clk);
        rst_n = 1'b1;
        auto_ack = 1'b1;
        wait_idle();

        // Random frames: good, truncated, bad sum, with noise between frames
        for (int n = 0; n < 30; n++) begin
            int kind;
            repeat ($urandom_range(0, 3)) begin
                chan_t b;
                b = 8'($urandom);
                if (b == DEF_SYNC0) b = 8'h00;
                send_byte(b, $urandom_range(0, 3));
            end
            kind = $urandom_range(0, 3);
            if (kind == 2) begin
                send_byte(DEF_SYNC0, 1);
                send_byte(DEF_SYNC1, 1);
                repeat ($urandom_range(0, NUM_CH - 1)) send_byte(8'($urandom), 1);
                repeat (GAP + 4) @(negedge clk);
                exp_err++;
`ifdef CHECKSUM_EN
            end else if (kind == 3) begin
                send_frame(rand_frame(), 0, 1, 0, 0);
                exp_err++;
`endif
            end else begin
                send_frame(rand_frame(), 1, 0, 1, 0);
            end
            wait_idle();
            chk_counters("rnd");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
